// File: rtl/mem_access_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_access_stage
//
// MEM pipeline stage between the EX/MEM and MEM/WB registers. It runs loads and
// stores against data memory over a req/ack bus and formats load data. It drives
// the MEM/WB inputs with their write enable, and stalls upstream while a memory
// access is outstanding.
//
// Non-memory instructions and bubbles pass straight through with no added
// latency. An aligned memory instruction takes IDLE -> ACCESS (one or more
// cycles, until ack) -> COMMIT, so it needs at least three cycles. A misaligned
// memory instruction is squashed in IDLE without touching the bus.
//
// Optional feature (compile-time macro MEM_TIMEOUT_EN):
//   When the macro is defined, an ACCESS that receives no ack for TIMEOUT_CYCLES
//   cycles is aborted. The stage then commits with no register write and pulses
//   bus_err. When the macro is undefined, ACCESS waits for ack indefinitely and
//   bus_err stays 0.
//
// Parameters
//   TIMEOUT_CYCLES  ACCESS cycles without ack before abort (MEM_TIMEOUT_EN only)
//   TCNT_W          timeout counter width, 2**TCNT_W > TIMEOUT_CYCLES
//
// Ports
//   clock, rst                  rising-edge clock, async active-high reset
//   ex_*                        EX/MEM register contents (ex_valid=0 is a bubble)
//   mem_wb, mem_regwrite,
//   mem_memout, mem_aluout,
//   mem_regrd, memwb_write      MEM/WB register inputs and its write enable
//   stall                       hold EX/MEM and earlier stages
//   misalign_err                1-cycle pulse, registered: the cycle after a
//                               misaligned access was squashed
//   bus_err                     1-cycle pulse on the COMMIT of a timed-out access
//   dmem_req/we/addr/be/wdata   memory request; held until dmem_ack
//   dmem_rdata, dmem_ack        memory response
// -----------------------------------------------------------------------------
module mem_access_stage #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TCNT_W         = 8
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_memread,
  input  logic        ex_memwrite,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_aluout,
  input  logic [31:0] ex_storedata,
  input  logic [4:0]  ex_regrd,
  input  logic        ex_wb,
  input  logic        ex_regwrite,
  output logic        mem_wb,
  output logic        mem_regwrite,
  output logic [31:0] mem_memout,
  output logic [31:0] mem_aluout,
  output logic [4:0]  mem_regrd,
  output logic        memwb_write,
  output logic        stall,
  output logic        misalign_err,
  output logic        bus_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  if (2 ** TCNT_W <= TIMEOUT_CYCLES) begin : g_cfg_check
    $error("mem_access_stage: TCNT_W too narrow for TIMEOUT_CYCLES");
  end

  // ---------------------------------------------------------------------------
  // Access formatting helpers
  // ---------------------------------------------------------------------------
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = lo[0];
      default: r = (lo != 2'b00);
    endcase
    return r;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] size,
                                         input logic [1:0] lo);
    logic [3:0] be;
    case (size)
      2'b00:   be = 4'b0001 << lo;
      2'b01:   be = lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // The store data is replicated across all lanes, so memory only needs the
  // byte enables to pick the right bytes.
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] data);
    logic [31:0] w;
    case (size)
      2'b00:   w = {4{data[7:0]}};
      2'b01:   w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] format_load(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lo,
                                              input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] f;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    h = lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'b00:   f = {{24{~uns & b[7]}}, b};
      2'b01:   f = {{16{~uns & h[15]}}, h};
      default: f = rdata;
    endcase
    return f;
  endfunction

  // ---------------------------------------------------------------------------
  // Decode of the instruction in EX/MEM (only meaningful in IDLE)
  // ---------------------------------------------------------------------------
  logic w_memop;
  logic w_misalign;
  logic w_start;
  logic w_squash;

  assign w_memop    = ex_valid & (ex_memread | ex_memwrite);
  assign w_misalign = is_misaligned(ex_size, ex_aluout[1:0]);
  assign w_start    = w_memop & ~w_misalign;
  assign w_squash   = w_memop &  w_misalign;

  // ---------------------------------------------------------------------------
  // State and latched fields
  // ---------------------------------------------------------------------------
  state_t      r_state;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic        r_load;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [31:0] r_aluout;
  logic [4:0]  r_regrd;
  logic        r_wb;
  logic        r_regwrite;
  logic [31:0] r_memout;
  logic        r_misalign_err;
  logic        r_bus_err;
  logic        w_timeout;

`ifdef MEM_TIMEOUT_EN
  localparam logic [TCNT_W-1:0] TO_LIMIT = TCNT_W'(TIMEOUT_CYCLES);

  logic [TCNT_W-1:0] r_tcnt;
  logic [TCNT_W-1:0] w_tcnt_inc;

  assign w_tcnt_inc = r_tcnt + 1'b1;
  // An ack in the same cycle takes priority over the timeout.
  assign w_timeout  = (r_state == S_ACCESS) & ~dmem_ack & (w_tcnt_inc == TO_LIMIT);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_tcnt <= '0;
    end else if (r_state == S_IDLE && w_start) begin
      r_tcnt <= '0;
    end else if (r_state == S_ACCESS && !dmem_ack) begin
      r_tcnt <= w_tcnt_inc;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_be           <= '0;
      r_wdata        <= '0;
      r_load         <= 1'b0;
      r_size         <= '0;
      r_unsigned     <= 1'b0;
      r_aluout       <= '0;
      r_regrd        <= '0;
      r_wb           <= 1'b0;
      r_regwrite     <= 1'b0;
      r_memout       <= '0;
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
    end else begin
      r_misalign_err <= 1'b0;
      r_bus_err      <= 1'b0;
      case (r_state)
        // IDLE -> ACCESS: launch the bus request and capture the instruction
        S_IDLE: begin
          if (w_squash) begin
            r_misalign_err <= 1'b1;
          end
          if (w_start) begin
            r_req      <= 1'b1;
            r_we       <= ex_memwrite;
            r_addr     <= {ex_aluout[31:2], 2'b00};
            r_be       <= lane_be(ex_size, ex_aluout[1:0]);
            r_wdata    <= lane_wdata(ex_size, ex_storedata);
            // A store wins when both memread and memwrite are set.
            r_load     <= ~ex_memwrite;
            r_size     <= ex_size;
            r_unsigned <= ex_unsigned;
            r_aluout   <= ex_aluout;
            r_regrd    <= ex_regrd;
            r_wb       <= ex_wb;
            r_regwrite <= ex_regwrite;
            r_memout   <= '0;
            r_state    <= S_ACCESS;
          end
        end
        // ACCESS -> COMMIT: on ack, or on timeout when that feature is built in
        S_ACCESS: begin
          if (dmem_ack) begin
            r_req    <= 1'b0;
            r_memout <= r_load ? format_load(r_size, r_unsigned, r_aluout[1:0], dmem_rdata)
                               : 32'd0;
            r_state  <= S_COMMIT;
          end else if (w_timeout) begin
            r_req     <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= S_COMMIT;
          end
        end
        // COMMIT -> IDLE: MEM/WB captures the result while EX/MEM advances
        S_COMMIT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // MEM/WB drive: pass-through in IDLE, latched fields otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_wb       = ex_wb;
    mem_regwrite = ex_valid & ex_regwrite;
    mem_memout   = '0;
    mem_aluout   = ex_aluout;
    mem_regrd    = ex_regrd;
    memwb_write  = 1'b1;
    stall        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_memop) begin
          mem_regwrite = 1'b0;
          if (w_start) begin
            memwb_write = 1'b0;
            stall       = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        mem_wb       = r_wb;
        mem_regwrite = 1'b0;
        mem_aluout   = r_aluout;
        mem_regrd    = r_regrd;
        memwb_write  = 1'b0;
        stall        = 1'b1;
      end
      S_COMMIT: begin
        mem_wb       = r_wb;
        // A timed-out access commits without writing the register file.
        mem_regwrite = r_regwrite & ~r_bus_err;
        mem_memout   = r_memout;
        mem_aluout   = r_aluout;
        mem_regrd    = r_regrd;
      end
      default: begin
        stall = 1'b0;
      end
    endcase
  end

  assign dmem_req     = r_req;
  assign dmem_we      = r_we;
  assign dmem_addr    = r_addr;
  assign dmem_be      = r_be;
  assign dmem_wdata   = r_wdata;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;

endmodule
